// File: rtl/if_fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package if_fetch_pkg;

    localparam int              PC_W_DEF     = 16;
    localparam int              INSTR_W_DEF  = 16;
    localparam logic [15:0]     RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} holding buffer for a response that arrives while ID is stalled.
module if_skid_buf
    import if_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    logic               full_r;
    logic [INSTR_W-1:0] instr_r;
    logic [PC_W-1:0]    pc_r;

    // Buffer register: clear/unload empty it, load captures a new entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r  <= 1'b0;
            instr_r <= '0;
            pc_r    <= '0;
        end else if (clear || unload) begin
            full_r  <= 1'b0;
        end else if (load) begin
            full_r  <= 1'b1;
            instr_r <= load_instr;
            pc_r    <= load_pc;
        end else begin
            full_r  <= full_r;
        end
    end

    assign full  = full_r;
    assign instr = instr_r;
    assign pc    = pc_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ready handshake
// and loads the IF/ID register, honouring stall and redirect.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               CLK,
    input  logic               RST_N,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    pc,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_next
);

    fetch_state_e       state_r, state_nxt_s;
    logic [PC_W-1:0]    pc_r, pc_nxt_s;
    logic [PC_W-1:0]    pend_addr_r;
    logic               pend_load_s;

    logic               ifid_valid_r;
    logic [INSTR_W-1:0] ifid_instr_r;
    logic [PC_W-1:0]    ifid_pc_r, ifid_pc_next_r;
    logic               ifid_load_s, ifid_flush_s;
    logic [INSTR_W-1:0] ifid_src_instr_s;
    logic [PC_W-1:0]    ifid_src_pc_s;

    logic               skid_load_s, skid_unload_s, skid_clear_s;
    logic               skid_full_s;
    logic [INSTR_W-1:0] skid_instr_s;
    logic [PC_W-1:0]    skid_pc_s;

    logic               req_s;
    logic [PC_W-1:0]    addr_s;

    if_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (CLK),
        .rst_n      (RST_N),
        .load       (skid_load_s),
        .unload     (skid_unload_s),
        .clear      (skid_clear_s),
        .load_instr (imem_rdata),
        .load_pc    (pc_r),
        .full       (skid_full_s),
        .instr      (skid_instr_s),
        .pc         (skid_pc_s)
    );

    // Next-state, next-PC and datapath controls; redirect outranks stall and fetch.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        pend_load_s      = 1'b0;
        ifid_load_s      = 1'b0;
        ifid_flush_s     = 1'b0;
        ifid_src_instr_s = imem_rdata;
        ifid_src_pc_s    = pc_r;
        skid_load_s      = 1'b0;
        skid_unload_s    = 1'b0;
        skid_clear_s     = 1'b0;
        req_s            = 1'b0;
        addr_s           = pc_r;
        case (state_r)
            ST_START: begin
                state_nxt_s = ST_FETCH;
                if (redirect) begin
                    pc_nxt_s     = redirect_pc;
                    ifid_flush_s = 1'b1;
                    skid_clear_s = 1'b1;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_FETCH: begin
                req_s = 1'b1;
                if (redirect) begin
                    pc_nxt_s     = redirect_pc;
                    ifid_flush_s = 1'b1;
                    skid_clear_s = 1'b1;
                    if (!imem_ready) begin
                        pend_load_s = 1'b1;
                        state_nxt_s = ST_DISCARD;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else if (imem_ready) begin
                    pc_nxt_s = pc_r + PC_W'(1);
                    if (!stall || !ifid_valid_r) begin
                        ifid_load_s = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        skid_load_s = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                ifid_src_instr_s = skid_instr_s;
                ifid_src_pc_s    = skid_pc_s;
                if (redirect) begin
                    pc_nxt_s     = redirect_pc;
                    ifid_flush_s = 1'b1;
                    skid_clear_s = 1'b1;
                    state_nxt_s  = ST_FETCH;
                end else if (!stall && skid_full_s) begin
                    ifid_load_s   = 1'b1;
                    skid_unload_s = 1'b1;
                    state_nxt_s   = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                req_s  = 1'b1;
                addr_s = pend_addr_r;
                if (redirect) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (imem_ready) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                state_nxt_s = ST_START;
            end
        endcase
    end

    // FSM, PC and pending-address registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_START;
            pc_r        <= RESET_PC;
            pend_addr_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            if (pend_load_s) begin
                pend_addr_r <= pc_r;
            end else begin
                pend_addr_r <= pend_addr_r;
            end
        end
    end

    // IF/ID pipeline register; payload is kept on flush, only valid drops.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ifid_valid_r   <= 1'b0;
            ifid_instr_r   <= '0;
            ifid_pc_r      <= '0;
            ifid_pc_next_r <= '0;
        end else if (ifid_flush_s) begin
            ifid_valid_r <= 1'b0;
        end else if (ifid_load_s) begin
            ifid_valid_r   <= 1'b1;
            ifid_instr_r   <= ifid_src_instr_s;
            ifid_pc_r      <= ifid_src_pc_s;
            ifid_pc_next_r <= ifid_src_pc_s + PC_W'(1);
        end else begin
            ifid_valid_r <= ifid_valid_r;
        end
    end

    assign imem_req     = req_s;
    assign imem_addr    = addr_s;
    assign pc           = pc_r;
    assign ifid_valid   = ifid_valid_r;
    assign ifid_instr   = ifid_instr_r;
    assign ifid_pc      = ifid_pc_r;
    assign ifid_pc_next = ifid_pc_next_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: flag-based reference model checked every
// cycle, plus hand-computed literal checkpoints.
module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_next;

    int n_pass  = 0;
    int n_total = 0;
    int mem_lat = 0;
    int mem_wait = 0;
    bit check_en = 1'b0;

    // reference model: started = past the idle cycle, held = stalled response parked,
    // ghost = squashed request still owed a response
    bit          m_started, m_held, m_ghost, m_v, m_done;
    logic [15:0] m_pc, m_ghost_addr, m_instr, m_ipc, m_ipcn, m_skid_instr, m_skid_pc;

    if_fetch_unit dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc           (pc),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pc_next (ifid_pc_next)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // memory answers 16'h1000+addr after mem_lat wait cycles per request
    task automatic tick(input bit s, input bit r, input logic [15:0] rp);
        @(negedge CLK);
        stall = s;
        redirect = r;
        redirect_pc = rp;
        if (imem_req === 1'b1) begin
            if (mem_wait == mem_lat) begin
                imem_ready = 1'b1;
                imem_rdata = 16'h1000 + imem_addr;
                mem_wait = 0;
            end else begin
                imem_ready = 1'b0;
                imem_rdata = 16'hDEAD;
                mem_wait++;
            end
        end else begin
            imem_ready = 1'b0;
            imem_rdata = 16'hDEAD;
            mem_wait = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    // model update at each rising edge from the inputs alone
    always @(posedge CLK) begin
        if (!RST_N) begin
            m_started = 1'b0; m_held = 1'b0; m_ghost = 1'b0; m_v = 1'b0;
            m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_ipcn = 16'h0000;
        end else begin
            m_done = m_started && !m_held && imem_ready;
            if (!m_started) begin
                m_started = 1'b1;
                if (redirect) begin m_pc = redirect_pc; m_v = 1'b0; end
            end else if (redirect) begin
                m_v = 1'b0;
                if (m_ghost) begin
                    if (m_done) m_ghost = 1'b0;
                end else if (!m_held && !m_done) begin
                    m_ghost = 1'b1;
                    m_ghost_addr = m_pc;
                end
                m_held = 1'b0;
                m_pc = redirect_pc;
            end else if (m_ghost) begin
                if (m_done) m_ghost = 1'b0;
            end else if (m_held) begin
                if (!stall) begin
                    m_v = 1'b1; m_instr = m_skid_instr; m_ipc = m_skid_pc;
                    m_ipcn = m_skid_pc + 16'd1; m_held = 1'b0;
                end
            end else if (m_done) begin
                if (!stall || !m_v) begin
                    m_v = 1'b1; m_instr = imem_rdata; m_ipc = m_pc; m_ipcn = m_pc + 16'd1;
                end else begin
                    m_skid_instr = imem_rdata; m_skid_pc = m_pc; m_held = 1'b1;
                end
                m_pc = m_pc + 16'd1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge CLK) begin
        if (check_en) begin
            chk("imem_req", 16'(imem_req), 16'(m_started && !m_held));
            if (m_started && !m_held)
                chk("imem_addr", imem_addr, m_ghost ? m_ghost_addr : m_pc);
            chk("pc", pc, m_pc);
            chk("ifid_valid", 16'(ifid_valid), 16'(m_v));
            if (m_v) begin
                chk("ifid_instr", ifid_instr, m_instr);
                chk("ifid_pc", ifid_pc, m_ipc);
                chk("ifid_pc_next", ifid_pc_next, m_ipcn);
            end
        end
    end

    initial begin
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        check_en = 1'b1;
        chk("rst_req", 16'(imem_req), 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", 16'(ifid_valid), 16'h0000);
        chk("rst_instr", ifid_instr, 16'h0000);
        chk("rst_pc_next", ifid_pc_next, 16'h0000);
        RST_N = 1'b1;

        // start cycle, then zero-wait sequential fetch
        tick(1'b0, 1'b0, 16'h0000);
        chk("first_req", 16'(imem_req), 16'h0001);
        chk("first_addr", imem_addr, 16'h0000);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0000);
        chk("seq_ifid_pc", ifid_pc, 16'h0003);
        chk("seq_instr", ifid_instr, 16'h1003);
        chk("seq_pc_next", ifid_pc_next, 16'h0004);
        chk("seq_pc", pc, 16'h0004);

        // stall while a response completes
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 16'h0000);
        chk("hold_req", 16'(imem_req), 16'h0000);
        chk("hold_ifid_pc", ifid_pc, 16'h0003);
        chk("hold_valid", 16'(ifid_valid), 16'h0001);
        chk("hold_pc", pc, 16'h0005);
        tick(1'b0, 1'b0, 16'h0000);
        chk("unskid_instr", ifid_instr, 16'h1004);
        chk("unskid_addr", imem_addr, 16'h0005);
        tick(1'b0, 1'b0, 16'h0000);

        // three wait cycles per request
        mem_lat = 3;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0000);
        chk("wait_req", 16'(imem_req), 16'h0001);
        chk("wait_addr", imem_addr, 16'h0006);
        chk("wait_pc", pc, 16'h0006);
        chk("wait_ifid_pc", ifid_pc, 16'h0005);
        tick(1'b0, 1'b0, 16'h0000);
        chk("wait_done_pc", pc, 16'h0007);
        chk("wait_done_instr", ifid_instr, 16'h1006);

        // get a request to 5 outstanding, then redirect to 0x40 under it
        tick(1'b0, 1'b1, 16'h0005);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b1, 16'h0040);
        chk("disc_req", 16'(imem_req), 16'h0001);
        chk("disc_addr", imem_addr, 16'h0005);
        chk("disc_pc", pc, 16'h0040);
        chk("disc_valid", 16'(ifid_valid), 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        chk("post_disc_addr", imem_addr, 16'h0040);
        chk("post_disc_valid", 16'(ifid_valid), 16'h0000);
        mem_lat = 0;
        tick(1'b0, 1'b0, 16'h0000);
        chk("tgt_valid", 16'(ifid_valid), 16'h0001);
        chk("tgt_pc", ifid_pc, 16'h0040);
        chk("tgt_instr", ifid_instr, 16'h1040);

        // zero-wait redirect latency
        tick(1'b0, 1'b1, 16'h0020);
        chk("zr_addr", imem_addr, 16'h0020);
        chk("zr_valid", 16'(ifid_valid), 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        chk("zr_ifid_pc", ifid_pc, 16'h0020);
        chk("zr_ifid_valid", 16'(ifid_valid), 16'h0001);

        // redirect beats stall
        tick(1'b1, 1'b1, 16'h0080);
        chk("rs_valid", 16'(ifid_valid), 16'h0000);
        chk("rs_pc", pc, 16'h0080);

        // PC wrap
        tick(1'b0, 1'b1, 16'hFFFE);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_ifid_pc", ifid_pc, 16'hFFFF);
        chk("wrap_pc_next", ifid_pc_next, 16'h0000);

        // reset with pc=FFFF and a request outstanding
        mem_lat = 3;
        tick(1'b0, 1'b1, 16'hFFFF);
        chk("pre_rst_pc", pc, 16'hFFFF);
        RST_N = 1'b0;
        tick(1'b0, 1'b0, 16'h0000);
        chk("mid_rst_pc", pc, 16'h0000);
        chk("mid_rst_req", 16'(imem_req), 16'h0000);
        chk("mid_rst_valid", 16'(ifid_valid), 16'h0000);
        chk("mid_rst_ifid_pc", ifid_pc, 16'h0000);
        RST_N = 1'b1;
        mem_lat = 0;
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        chk("restart_pc", ifid_pc, 16'h0000);
        chk("restart_instr", ifid_instr, 16'h1000);
        tick(1'b0, 1'b0, 16'h0000);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
